// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: state codes and default operand width.
package mul_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t LOAD  = 2'd1;
    localparam state_t SHIFT = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/multiplier_control_if.sv
// Control/status bundle between the multiplier sequencer (slave) and the datapath side (master).
interface multiplier_control_if
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) ();

    logic             start;
    logic             lsb;
    logic             wrctrl;
    logic             addctrl;
    logic             strctrl;
    logic             ready;
    logic             done;
    logic [CNT_W-1:0] count;

    modport master (
        output start, lsb,
        input  wrctrl, addctrl, strctrl, ready, done, count
    );

    modport slave (
        input  start, lsb,
        output wrctrl, addctrl, strctrl, ready, done, count
    );

endinterface

// File: rtl/mul_iter_counter.sv
// Iteration counter: synchronous clear, saturating increment at WIDTH, terminal flag at WIDTH-1.
module mul_iter_counter
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && count != FULL) begin
            count <= count + CNT_W'(1);
        end
    end

    always_comb terminal = (count == LAST);

endmodule

// File: rtl/multiplier_control.sv
// Shift-add multiplier sequencer: one product load, WIDTH add/shift iterations, one done cycle.
module multiplier_control
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    multiplier_control_if.slave   bus
);

    state_t           state;
    state_t           next_state;
    logic             terminal;
    logic [CNT_W-1:0] iter_count;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (terminal) next_state = DONE;
            DONE:    next_state = bus.start ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Clearing on LOAD entry makes count read 0 for the whole LOAD cycle.
    mul_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (next_state == LOAD),
        .enable   (state == SHIFT),
        .count    (iter_count),
        .terminal (terminal)
    );

    always_comb bus.count = iter_count;

    // Registered outputs are decoded from next_state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus.wrctrl  <= 1'b0;
            bus.strctrl <= 1'b0;
            bus.done    <= 1'b0;
            bus.ready   <= 1'b1;
        end else begin
            state       <= next_state;
            bus.wrctrl  <= (next_state == LOAD);
            bus.strctrl <= (next_state == SHIFT);
            bus.done    <= (next_state == DONE);
            bus.ready   <= (next_state == IDLE) || (next_state == DONE);
        end
    end

    always_comb bus.addctrl = (state == SHIFT) && bus.lsb;

endmodule

// File: tb/tb_multiplier_control.sv
// Randomised bench for multiplier_control with a shift-add datapath and a timeline reference model.
module tb_multiplier_control;
    import mul_pkg::*;

    localparam int unsigned W  = DEFAULT_WIDTH;
    localparam int unsigned CW = $clog2(W) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiplier_control_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    multiplier_control #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] prod;
        int          done_t;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Product register and adder, sampling controls on negedge like the real datapath.
    logic [31:0] mcand = '0;
    logic [63:0] prod  = '0;
    logic [31:0] op_a, op_b, pa, pb;

    function automatic logic [63:0] step(input logic [63:0] p, input logic [31:0] m, input logic add);
        logic [32:0] s;
        s = {1'b0, p[63:32]} + (add ? {1'b0, m} : 33'd0);
        return {s, p[31:1]};
    endfunction

    always_comb bus.lsb = prod[0];

    always @(negedge clk) begin
        if (bus.wrctrl) begin
            mcand <= pa;
            prod  <= {32'd0, pb};
        end else if (bus.strctrl && !bus.ready) begin
            prod <= step(prod, mcand, bus.addctrl);
        end
    end

    // Reference model: an accepted start at edge t0 fixes the whole timeline of that operation.
    int       t = 0;
    int       t0 = 0;
    bit       active = 1'b0;
    bit       valid = 1'b0;
    logic     e_wr, e_str, e_done, e_ready, e_add;
    logic [CW-1:0] e_cnt;

    task automatic model_step();
        int d;
        t = t + 1;
        if (rst) begin
            active = 1'b0;
            valid  = 1'b1;
            sb.delete();
        end else if (valid && bus.start && (!active || (t - t0) >= int'(W) + 2)) begin
            active = 1'b1;
            t0     = t;
            pa     = op_a;
            pb     = op_b;
            sb.push_back('{64'(op_a) * 64'(op_b), t + int'(W) + 1});
        end
        e_wr = 1'b0; e_str = 1'b0; e_done = 1'b0; e_ready = 1'b1; e_add = 1'b0; e_cnt = '0;
        if (active) begin
            d = t - t0;
            if (d == 0) begin
                e_wr = 1'b1; e_ready = 1'b0;
            end else if (d <= int'(W)) begin
                e_str = 1'b1; e_ready = 1'b0; e_cnt = CW'(d - 1); e_add = pb[d-1];
            end else begin
                e_cnt  = CW'(W);
                e_done = (d == int'(W) + 1);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, t);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (valid) begin
            check("wrctrl",  bus.wrctrl,  e_wr);
            check("strctrl", bus.strctrl, e_str);
            check("done",    bus.done,    e_done);
            check("ready",   bus.ready,   e_ready);
            check("count",   bus.count,   e_cnt);
            check("addctrl", bus.addctrl, e_add);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product",   prod, e.prod);
                    check("done_time", t,    e.done_t);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(bus.ready === 1'b1 && bus.done === 1'b0) && n < 200) begin
            cyc(1);
            n++;
        end
        if (n >= 200) check("idle_timeout", 64'd1, 64'd0);
        cyc(1);
    endtask

    task automatic one_op(input logic [31:0] a, input logic [31:0] b);
        op_a = a;
        op_b = b;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.start = 1'b0;
        op_a = '0;
        op_b = '0;
        cyc(2);
        rst = 1'b0;
        cyc(2);

        one_op(32'd7, 32'd6);
        wait_idle();
        one_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();

        // A start pulse in the middle of SHIFT must not disturb the running operation.
        one_op($urandom, 32'hA5A5_A5A5);
        cyc(8);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        wait_idle();

        bus.start = 1'b1;
        repeat (3 * (W + 2) + 1) begin
            op_a = $urandom;
            op_b = $urandom;
            cyc(1);
        end
        bus.start = 1'b0;
        wait_idle();

        one_op($urandom, $urandom);
        n = 0;
        while (!(bus.strctrl === 1'b1 && bus.count === CW'(10)) && n < 60) begin
            cyc(1);
            n++;
        end
        if (n >= 60) check("count10_timeout", 64'd1, 64'd0);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(3);

        repeat (800) begin
            bus.start = ($urandom_range(0, 5) == 0);
            op_a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            op_b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            cyc(1);
        end
        bus.start = 1'b0;
        wait_idle();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
